debug_halt_unit: RTL and testbench

DEBUG_HALT_UNIT -- requirements
Module: debug_halt_unit

---
 rtl/debug_halt_unit.sv | 99 +++++++++
 tb/tb_debug_halt_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_halt_unit.sv
// debug_halt_unit: halts the CPU on a PC breakpoint or cycle timeout, then streams
// the register file out over a valid/ready dump port.
module debug_halt_unit #(
    parameter  int NUM_BP  = 4,
    parameter  int PC_W    = 32,
    parameter  int DATA_W  = 32,
    parameter  int REG_CNT = 32,
    parameter  int TMO_W   = 16,
    localparam int SEL_W   = $clog2(REG_CNT),
    localparam int BID_W   = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [PC_W-1:0]        pc,
    input  logic                   pc_valid,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    input  logic [TMO_W-1:0]       tmo_lim,
    output logic                   halt,
    output logic [1:0]             halt_cause,
    output logic [BID_W-1:0]       bp_id,
    output logic [SEL_W-1:0]       reg_sel,
    input  logic [DATA_W-1:0]      reg_data,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [SEL_W-1:0]       dump_idx,
    output logic [DATA_W-1:0]      dump_data,
    output logic                   done
);
    typedef enum logic [1:0] {IDLE, RUN, DUMP, DONE} state_t;

    state_t           state, state_nxt;
    logic [TMO_W-1:0] cnt;
    logic [1:0]       cause;
    logic [BID_W-1:0] id, hit_id;
    logic [SEL_W-1:0] idx;
    logic             hit, tmo, arm, beat, last;

    // descending scan so the lowest matching channel is the one left standing
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int i = NUM_BP - 1; i >= 0; i--)
            if (pc_valid && bp_en[i] && pc == bp_addr[i*PC_W +: PC_W]) begin
                hit    = 1'b1;
                hit_id = BID_W'(i);
            end
    end

    assign tmo  = state == RUN && tmo_lim != '0 && cnt == tmo_lim - TMO_W'(1);
    assign arm  = start && (state == IDLE || state == DONE);
    assign beat = state == DUMP && dump_ready;
    assign last = beat && idx == SEL_W'(REG_CNT - 1);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? RUN : state;
            RUN:        state_nxt = (hit || tmo) ? DUMP : RUN;
            DUMP:       state_nxt = last ? DONE : DUMP;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            cnt   <= '0;
            cause <= '0;
            id    <= '0;
            idx   <= '0;
        end else if (arm) begin
            cnt   <= '0;
            cause <= '0;
            id    <= '0;
            idx   <= '0;
        end else if (state == RUN) begin
            cnt <= (&cnt) ? cnt : cnt + TMO_W'(1);
            if (hit || (state == RUN && tmo)) begin
                cause <= {tmo, state == RUN && hit};
                id    <= hit_id;
            end
        end else if (beat) begin
            idx <= last ? '0 : idx + SEL_W'(1);
        end

    assign halt       = state == DUMP || state == DONE;
    assign done       = state == DONE;
    assign dump_valid = state == DUMP;
    assign halt_cause = cause;
    assign bp_id      = id;
    assign dump_idx   = idx;
    assign reg_sel    = dump_valid ? idx : '0;
    assign dump_data  = (dump_valid && idx != '0) ? reg_data : '0;
endmodule

// File: tb/tb_debug_halt_unit.sv
// tb_debug_halt_unit: randomized and directed checks of debug_halt_unit against a
// per-run reference model (first trigger cycle, cause, winning channel, beat list).
module tb_debug_halt_unit;
    localparam int NB = 4, PW = 32, DW = 32, RC = 32, TW = 16, SEQ = 64;

    logic           clk = 1'b0, rstn = 1'b0, start = 1'b0, pc_valid = 1'b0, dump_ready = 1'b0;
    logic [PW-1:0]  pc = '0;
    logic [NB*PW-1:0] bp_addr = '0;
    logic [NB-1:0]  bp_en = '0;
    logic [TW-1:0]  tmo_lim = '0;
    logic           halt, done, dump_valid;
    logic [1:0]     halt_cause, bp_id;
    logic [4:0]     reg_sel, dump_idx;
    logic [DW-1:0]  reg_data, dump_data;

    logic [DW-1:0]  rf [RC];
    logic [PW-1:0]  pc_seq [SEQ];
    logic           vld_seq [SEQ];
    int total = 0, bad = 0;

    always #5 clk = ~clk;
    assign reg_data = rf[reg_sel];

    debug_halt_unit #(.NUM_BP(NB), .PC_W(PW), .DATA_W(DW), .REG_CNT(RC), .TMO_W(TW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .pc(pc), .pc_valid(pc_valid),
        .bp_addr(bp_addr), .bp_en(bp_en), .tmo_lim(tmo_lim), .halt(halt),
        .halt_cause(halt_cause), .bp_id(bp_id), .reg_sel(reg_sel), .reg_data(reg_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_idx(dump_idx),
        .dump_data(dump_data), .done(done)
    );

    // Reference: the run halts after the first RUN cycle k where a valid pc matches an
    // enabled channel or k equals a nonzero tmo_lim.
    function automatic void model(output int at, output logic [1:0] c, output int id);
        at = 0; c = 2'b00; id = 0;
        for (int k = 1; k <= SEQ && at == 0; k++) begin
            int h;
            logic to;
            h = -1;
            if (vld_seq[k-1])
                for (int i = 0; i < NB; i++)
                    if (h < 0 && bp_en[i] && pc_seq[k-1] == bp_addr[i*PW +: PW]) h = i;
            to = tmo_lim != 0 && k == int'(tmo_lim);
            if (h >= 0 || to) begin
                at = k;
                c  = {to, h >= 0};
                id = (h < 0) ? 0 : h;
            end
        end
    endfunction

    task automatic set_bp(input int ch, input logic [PW-1:0] a);
        bp_addr[ch*PW +: PW] = a;
    endtask

    task automatic fill_idle_seq();
        for (int k = 0; k < SEQ; k++) begin
            pc_seq[k]  = 32'h1000 + 32'(k * 4);
            vld_seq[k] = 1'b0;
        end
    endtask

    task automatic run_case(input string nm);
        int at, id;
        logic [1:0] c;
        model(at, c, id);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        total++;
        if (halt !== 1'b0 || done !== 1'b0 || halt_cause !== 2'b00 || bp_id !== 2'd0 || dump_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s enter_run: halt=%b done=%b cause=%b bp_id=%0d valid=%b, required all 0",
                     nm, halt, done, halt_cause, bp_id, dump_valid);
        end
        if (at == 0) begin
            bad++;
            $display("FAIL %s model: no trigger within %0d cycles", nm, SEQ);
            return;
        end
        for (int k = 1; k <= at; k++) begin
            pc = pc_seq[k-1];
            pc_valid = vld_seq[k-1];
            @(negedge clk);
            if (k < at) begin
                total++;
                if (halt !== 1'b0) begin
                    bad++;
                    $display("FAIL %s early_halt: cycle %0d halt=%b, required 0", nm, k, halt);
                end
            end
        end
        pc_valid = 1'b0;
        total++;
        if (halt !== 1'b1 || halt_cause !== c || (c[0] && bp_id !== id[1:0]) || dump_valid !== 1'b1 || dump_idx !== 5'd0) begin
            bad++;
            $display("FAIL %s halt: halt=%b cause=%b bp_id=%0d valid=%b idx=%0d, required 1 %b %0d 1 0",
                     nm, halt, halt_cause, bp_id, dump_valid, dump_idx, c, id);
        end
    endtask

    // mode 0: ready 1,0,0,1 repeating; 1: random ready with stray start pulses; 2: always ready
    task automatic do_dump(input string nm, input int mode, input int stop_at);
        int e, cyc;
        logic r;
        logic [DW-1:0] exp_d;
        e = 0; cyc = 0;
        while (e < stop_at && cyc < 400) begin
            exp_d = (e == 0) ? '0 : rf[e];
            total++;
            if (dump_valid !== 1'b1 || halt !== 1'b1 || done !== 1'b0 || dump_idx !== 5'(e) || reg_sel !== 5'(e) || dump_data !== exp_d) begin
                bad++;
                $display("FAIL %s beat: valid=%b halt=%b done=%b idx=%0d sel=%0d data=%h, required 1 1 0 %0d %0d %h",
                         nm, dump_valid, halt, done, dump_idx, reg_sel, dump_data, e, e, exp_d);
            end
            r = (mode == 0) ? (cyc % 4 == 0 || cyc % 4 == 3) : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
            dump_ready = r;
            @(negedge clk);
            if (r) e++;
            cyc++;
        end
        dump_ready = 1'b0;
        start = 1'b0;
        if (cyc >= 400) begin
            bad++;
            total++;
            $display("FAIL %s dump_timeout: accepted=%0d, required %0d", nm, e, stop_at);
        end else if (stop_at == RC) begin
            total++;
            if (done !== 1'b1 || dump_valid !== 1'b0 || halt !== 1'b1 || reg_sel !== 5'd0) begin
                bad++;
                $display("FAIL %s done: done=%b valid=%b halt=%b sel=%0d, required 1 0 1 0",
                         nm, done, dump_valid, halt, reg_sel);
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        total++;
        if (halt !== 1'b0 || halt_cause !== 2'b00 || bp_id !== 2'd0 || dump_idx !== 5'd0 || dump_valid !== 1'b0 ||
            done !== 1'b0 || reg_sel !== 5'd0 || dump_data !== '0) begin
            bad++;
            $display("FAIL %s reset_outputs: halt=%b cause=%b id=%0d idx=%0d valid=%b done=%b sel=%0d data=%h, required all 0",
                     nm, halt, halt_cause, bp_id, dump_idx, dump_valid, done, reg_sel, dump_data);
        end
    endtask

    task automatic idle_hold(input string nm, input int n);
        for (int k = 0; k < n; k++) begin
            pc = bp_addr[PW-1:0];
            pc_valid = 1'b1;
            @(negedge clk);
            total++;
            if (halt !== 1'b0 || done !== 1'b0 || dump_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s idle_hold: halt=%b done=%b valid=%b, required 0 0 0", nm, halt, done, dump_valid);
            end
        end
        pc_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2 check_reset_outputs("reset");
        @(negedge clk); rstn = 1'b1;
        bp_en = 4'b0001;
        set_bp(0, 32'h0);
        idle_hold("reset", 4);
        bp_en = '0;
    endtask

    task automatic test_breakpoint();
        fill_idle_seq();
        bp_en = 4'b0010; tmo_lim = '0;
        set_bp(1, 32'h8);
        pc_seq[0] = 32'h0; pc_seq[1] = 32'h4; pc_seq[2] = 32'h8;
        vld_seq[0] = 1'b1; vld_seq[1] = 1'b1; vld_seq[2] = 1'b1;
        run_case("breakpoint");
        do_dump("breakpoint", 2, RC);
    endtask

    task automatic test_timeout();
        fill_idle_seq();
        bp_en = '0; tmo_lim = 16'd5;
        for (int k = 0; k < SEQ; k++) vld_seq[k] = 1'b1;
        run_case("timeout");
        do_dump("timeout_stall", 0, RC);
    endtask

    task automatic test_simultaneous();
        fill_idle_seq();
        bp_en = 4'b1100; tmo_lim = 16'd3;
        set_bp(0, 32'h10); set_bp(1, 32'h14); set_bp(2, 32'h10); set_bp(3, 32'h10);
        pc_seq[0] = 32'h0; pc_seq[1] = 32'h14; pc_seq[2] = 32'h10;
        for (int k = 0; k < 3; k++) vld_seq[k] = 1'b1;
        run_case("simultaneous");
        do_dump("simultaneous", 2, RC);
    endtask

    task automatic test_reset_mid_dump();
        fill_idle_seq();
        bp_en = 4'b0100; tmo_lim = '0;
        set_bp(2, 32'h40);
        pc_seq[1] = 32'h40; vld_seq[1] = 1'b1;
        run_case("mid_reset");
        do_dump("mid_reset", 1, 12);
        total++;
        if (dump_idx !== 5'd12 || dump_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset pre: idx=%0d valid=%b, required 12 1", dump_idx, dump_valid);
        end
        #2 rstn = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk); rstn = 1'b1;
        check_reset_outputs("mid_reset_release");
        idle_hold("mid_reset", 3);
        run_case("mid_reset_rerun");
        do_dump("mid_reset_rerun", 1, RC);
    endtask

    task automatic test_restart_from_done();
        fill_idle_seq();
        bp_en = 4'b1000; tmo_lim = 16'd50;
        set_bp(3, 32'hC);
        pc_seq[4] = 32'hC; vld_seq[4] = 1'b1;
        run_case("restart");
        do_dump("restart", 2, RC);
    endtask

    task automatic test_random(input int n);
        for (int r = 0; r < n; r++) begin
            for (int i = 0; i < RC; i++) rf[i] = $urandom;
            bp_en = 4'($urandom_range(0, 15));
            tmo_lim = 16'($urandom_range(1, 40));
            for (int i = 0; i < NB; i++) set_bp(i, 32'($urandom_range(0, 15) * 4));
            for (int k = 0; k < SEQ; k++) begin
                pc_seq[k]  = 32'($urandom_range(0, 15) * 4);
                vld_seq[k] = $urandom_range(0, 3) != 0;
            end
            run_case($sformatf("random%0d", r));
            do_dump($sformatf("random%0d", r), r % 3, RC);
        end
    endtask

    initial begin
        for (int i = 0; i < RC; i++) rf[i] = $urandom;
        rf[0] = 32'hDEADBEEF;
        test_reset();
        test_breakpoint();
        test_timeout();
        test_simultaneous();
        test_restart_from_done();
        test_reset_mid_dump();
        test_random(6);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
